alu_mc: RTL and testbench
=========================

# alu_mc

Multicycle, parametrised ALU for the multicycle datapath. It adds logic, shift, iterative unsigned multiply and restoring divide to add/sub, and takes a start/busy/done handshake from the control FSM. Operands are latched on `start`. Results and flags are registered and held until the next operation completes. Single-cycle ops finish in 1 cycle; MUL/DIV finish in DATA_BUS_WIDTH cycles.

## Interface
- `DATA_BUS_WIDTH`, default 16: operand/result width W, ≥4.
- `ALU_OP_NUM_BITS`, default 4: opcode width.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high.
- `start`  in  1: request; sampled only when `busy`=0.
- `Alu_Op`  in  ALU_OP_NUM_BITS: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR (logical), 7 MUL, 8 DIV; others are NOP.
- `A`, `B`  in  W: operands, latched with `start`.
- `result`  out  W: low half (MUL), quotient (DIV), else the result.
- `result_hi`  out  W: product high half (MUL), remainder (DIV), else 0.
- `Z`, `C`, `N`, `V`  out  1 each: registered flags.
- `busy`  out  1: operation in progress.
- `done`  out  1: one-cycle pulse when outputs update.

## Operation
- FSM states are IDLE and ITER. Reset forces IDLE.
- Reset clears every output to 0: `result`, `result_hi`, `Z`, `C`, `N`, `V`, `busy`, `done`.
- IDLE with `start`=1 on edge k latches A, B and Alu_Op.
  - Single-cycle ops and NOP write outputs at edge k. `done`=1 for one cycle; state stays IDLE.
  - MUL/DIV with B≠0 enter ITER with iteration count 0. `busy`=1 from edge k.
  - DIV with B=0 completes at edge k: `result` all ones, `result_hi`=A, V=1, C=0.
- ITER performs one iteration per edge.
  - MUL is shift-add over B bits, LSB first, into a 2W accumulator.
  - DIV is a restoring shift-subtract, MSB first.
  - At count W-1, outputs are written, `done` pulses, `busy` drops and state returns to IDLE.
- `start` while `busy`=1 is ignored; no queueing.
- Arithmetic and flag rules:
  - ADD: {C,result}=A+B in W+1 bits. V = signed overflow.
  - SUB: {C,result}=A+~B+1. C=1 means no borrow. V = signed overflow.
  - AND/OR/XOR: C=0, V=0.
  - SHL/SHR: shift amount = B[clog2(W)-1:0]. C = last bit shifted out, or 0 if the amount is 0. V=0.
  - MUL: unsigned, {result_hi,result} = A*B. C=0. V=1 iff result_hi≠0.
  - DIV: unsigned. C=0, V=0 unless dividing by zero.
  - NOP: result=0, result_hi=0, Z=1, other flags 0.
- Z=1 iff `result`=0. For MUL, Z=1 iff the full 2W product is 0.
- N = `result`[W-1].
- Outputs and flags hold between completions. `done` is the only pulse.
- Asserting `reset` mid-ITER aborts immediately: no `done`, outputs cleared.

## Timing
- Latency from the `start` edge to the `done` edge:
  - 0 extra edges for single-cycle ops (outputs valid the cycle after the `start` sample).
  - W edges for MUL/DIV (W=16: done 16 cycles after start).
- Throughput: back-to-back single-cycle ops every cycle; MUL/DIV one per W+1 cycles.
- `busy` and `done` are never both 1. `busy` falls on the same edge that `done` rises.
- A new `start` is accepted in the cycle `done` is high.
- `start` in the same cycle reset deasserts is accepted only on the first rising edge with `reset`=0.
- Combinational inputs do not reach outputs; all outputs are registered.

## Test plan
- Reset and add flags, W=16.
  - Stimulus: reset, then ADD A=FFFF, B=0001.
  - Required: all outputs 0 after reset; then result=0000, Z=1, C=1, V=0, `done` pulse next cycle.
- Signed overflow on SUB.
  - Stimulus: SUB A=8000, B=0001.
  - Required: result=7FFF, C=1, V=1, N=0.
- Shift carry-out.
  - Stimulus: SHL A=8001, B=1.
  - Required: result=0002, C=1.
  - Stimulus: SHR A=0001, B=0.
  - Required: result=0001, C=0.
- Multiply.
  - Stimulus: MUL A=FFFF, B=FFFF.
  - Required: `busy` for 16 cycles; `done` at cycle 16; result=0001, result_hi=FFFE, V=1. A `start` issued mid-run is ignored.
- Divide and divide by zero.
  - Stimulus: DIV A=0064, B=0007.
  - Required: result=000E, result_hi=0002 after 16 cycles.
  - Stimulus: DIV A=1234, B=0.
  - Required: result=FFFF, result_hi=1234, V=1 after 1 cycle.
- Reset mid-operation.
  - Stimulus: assert `reset` at cycle 5 of a MUL.
  - Required: no `done`; outputs 0; a subsequent ADD 2+3 gives result=0005.

Source files
------------

// File: rtl/alu_mc.sv
// Multicycle ALU: single-cycle add/sub/logic/shift plus iterative unsigned
// multiply (shift-add) and restoring divide behind a start/busy/done handshake.
module alu_mc #(
    parameter int DATA_BUS_WIDTH  = 16,
    parameter int ALU_OP_NUM_BITS = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [ALU_OP_NUM_BITS-1:0] Alu_Op,
    input  logic [DATA_BUS_WIDTH-1:0]  A,
    input  logic [DATA_BUS_WIDTH-1:0]  B,
    output logic [DATA_BUS_WIDTH-1:0]  result,
    output logic [DATA_BUS_WIDTH-1:0]  result_hi,
    output logic                       Z,
    output logic                       C,
    output logic                       N,
    output logic                       V,
    output logic                       busy,
    output logic                       done
);
    localparam int W  = DATA_BUS_WIDTH;
    localparam int SW = $clog2(W);
    localparam int CW = $clog2(W);

    typedef logic [ALU_OP_NUM_BITS-1:0] op_t;
    localparam op_t OP_ADD = op_t'(0);
    localparam op_t OP_SUB = op_t'(1);
    localparam op_t OP_AND = op_t'(2);
    localparam op_t OP_OR  = op_t'(3);
    localparam op_t OP_XOR = op_t'(4);
    localparam op_t OP_SHL = op_t'(5);
    localparam op_t OP_SHR = op_t'(6);
    localparam op_t OP_MUL = op_t'(7);
    localparam op_t OP_DIV = op_t'(8);

    typedef enum logic {IDLE = 1'b0, ITER = 1'b1} state_t;

    state_t          state_r, state_s;
    logic            mul_r, mul_s;
    logic [W-1:0]    opd_r, opd_s;
    logic [W-1:0]    hi_r, hi_s;
    logic [W-1:0]    lo_r, lo_s;
    logic [CW-1:0]   cnt_r, cnt_s;
    logic [W-1:0]    result_s, result_hi_s;
    logic            z_s, c_s, n_s, v_s, busy_s, done_s;

    logic [SW-1:0]   sh_s;
    logic [W:0]      add_s, sub_s, shl_s, shr_s;
    logic [W-1:0]    sc_res_s;
    logic            sc_c_s, sc_v_s;
    logic [W:0]      mul_sum_s, div_sh_s;
    logic [W-1:0]    div_diff_s, it_hi_s, it_lo_s;
    logic            div_ge_s;

    // Single-cycle datapath evaluated straight from the inputs at the start edge.
    always_comb begin
        sh_s     = B[SW-1:0];
        add_s    = {1'b0, A} + {1'b0, B};
        sub_s    = {1'b0, A} + {1'b0, ~B} + {{W{1'b0}}, 1'b1};
        shl_s    = {1'b0, A} << sh_s;
        shr_s    = {A, 1'b0} >> sh_s;
        sc_res_s = {W{1'b0}};
        sc_c_s   = 1'b0;
        sc_v_s   = 1'b0;
        case (Alu_Op)
            OP_ADD: begin
                sc_res_s = add_s[W-1:0];
                sc_c_s   = add_s[W];
                sc_v_s   = (A[W-1] == B[W-1]) && (add_s[W-1] != A[W-1]);
            end
            OP_SUB: begin
                sc_res_s = sub_s[W-1:0];
                sc_c_s   = sub_s[W];
                sc_v_s   = (A[W-1] != B[W-1]) && (sub_s[W-1] != A[W-1]);
            end
            OP_AND: sc_res_s = A & B;
            OP_OR:  sc_res_s = A | B;
            OP_XOR: sc_res_s = A ^ B;
            OP_SHL: begin
                sc_res_s = shl_s[W-1:0];
                sc_c_s   = shl_s[W];
            end
            OP_SHR: begin
                sc_res_s = shr_s[W:1];
                sc_c_s   = shr_s[0];
            end
            default: sc_res_s = {W{1'b0}};
        endcase
    end

    // One multiply or divide iteration on the shared hi/lo working registers.
    always_comb begin
        mul_sum_s  = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opd_r} : {(W+1){1'b0}});
        div_sh_s   = {hi_r, lo_r[W-1]};
        div_ge_s   = (div_sh_s >= {1'b0, opd_r});
        div_diff_s = div_sh_s[W-1:0] - opd_r;
        if (mul_r) begin
            it_hi_s = mul_sum_s[W:1];
            it_lo_s = {mul_sum_s[0], lo_r[W-1:1]};
        end else if (div_ge_s) begin
            it_hi_s = div_diff_s;
            it_lo_s = {lo_r[W-2:0], 1'b1};
        end else begin
            it_hi_s = div_sh_s[W-1:0];
            it_lo_s = {lo_r[W-2:0], 1'b0};
        end
    end

    // Next-state and next-output logic; outputs hold unless an op completes.
    always_comb begin
        state_s     = state_r;
        mul_s       = mul_r;
        opd_s       = opd_r;
        hi_s        = hi_r;
        lo_s        = lo_r;
        cnt_s       = cnt_r;
        result_s    = result;
        result_hi_s = result_hi;
        z_s         = Z;
        c_s         = C;
        n_s         = N;
        v_s         = V;
        busy_s      = busy;
        done_s      = 1'b0;
        case (state_r)
            IDLE: begin
                busy_s = 1'b0;
                if (start) begin
                    case (Alu_Op)
                        OP_MUL, OP_DIV: begin
                            if (B != {W{1'b0}}) begin
                                state_s = ITER;
                                busy_s  = 1'b1;
                                mul_s   = (Alu_Op == OP_MUL);
                                opd_s   = (Alu_Op == OP_MUL) ? A : B;
                                hi_s    = {W{1'b0}};
                                lo_s    = (Alu_Op == OP_MUL) ? B : A;
                                cnt_s   = {CW{1'b0}};
                            end else if (Alu_Op == OP_DIV) begin
                                result_s    = {W{1'b1}};
                                result_hi_s = A;
                                z_s         = 1'b0;
                                c_s         = 1'b0;
                                n_s         = 1'b1;
                                v_s         = 1'b1;
                                done_s      = 1'b1;
                            end else begin
                                result_s    = {W{1'b0}};
                                result_hi_s = {W{1'b0}};
                                z_s         = 1'b1;
                                c_s         = 1'b0;
                                n_s         = 1'b0;
                                v_s         = 1'b0;
                                done_s      = 1'b1;
                            end
                        end
                        default: begin
                            result_s    = sc_res_s;
                            result_hi_s = {W{1'b0}};
                            z_s         = (sc_res_s == {W{1'b0}});
                            c_s         = sc_c_s;
                            n_s         = sc_res_s[W-1];
                            v_s         = sc_v_s;
                            done_s      = 1'b1;
                        end
                    endcase
                end else begin
                    state_s = IDLE;
                end
            end
            ITER: begin
                hi_s = it_hi_s;
                lo_s = it_lo_s;
                if (cnt_r == CW'(W - 1)) begin
                    state_s     = IDLE;
                    busy_s      = 1'b0;
                    done_s      = 1'b1;
                    result_s    = it_lo_s;
                    result_hi_s = it_hi_s;
                    z_s         = mul_r ? ({it_hi_s, it_lo_s} == {(2*W){1'b0}})
                                        : (it_lo_s == {W{1'b0}});
                    c_s         = 1'b0;
                    n_s         = it_lo_s[W-1];
                    v_s         = mul_r ? (it_hi_s != {W{1'b0}}) : 1'b0;
                end else begin
                    cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_s = IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State, working registers and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            mul_r     <= 1'b0;
            opd_r     <= {W{1'b0}};
            hi_r      <= {W{1'b0}};
            lo_r      <= {W{1'b0}};
            cnt_r     <= {CW{1'b0}};
            result    <= {W{1'b0}};
            result_hi <= {W{1'b0}};
            Z         <= 1'b0;
            C         <= 1'b0;
            N         <= 1'b0;
            V         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_r   <= state_s;
            mul_r     <= mul_s;
            opd_r     <= opd_s;
            hi_r      <= hi_s;
            lo_r      <= lo_s;
            cnt_r     <= cnt_s;
            result    <= result_s;
            result_hi <= result_hi_s;
            Z         <= z_s;
            C         <= c_s;
            N         <= n_s;
            V         <= v_s;
            busy      <= busy_s;
            done      <= done_s;
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: stimulus pushes expected results, a negedge
// monitor pops and compares whenever done is seen.
module tb_alu_mc;
    localparam int W = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [3:0]    Alu_Op;
    logic [W-1:0]  A, B;
    logic [W-1:0]  result, result_hi;
    logic          Z, C, N, V, busy, done;

    typedef struct {
        string       name;
        logic [15:0] res;
        logic [15:0] hi;
        logic [3:0]  flags;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   done_seen = 0;

    alu_mc #(.DATA_BUS_WIDTH(W), .ALU_OP_NUM_BITS(4)) dut (
        .clk(clk), .reset(reset), .start(start), .Alu_Op(Alu_Op),
        .A(A), .B(B), .result(result), .result_hi(result_hi),
        .Z(Z), .C(C), .N(N), .V(V), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares every completed operation against the scoreboard head.
    always @(negedge clk) begin
        if (busy && done) begin
            tests++;
            fails++;
            $display("FAIL busy_done_overlap: got busy=1 done=1 expected not both");
        end
        if (done === 1'b1) begin
            done_seen++;
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done with result %h expected no done", result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_result"}, {16'h0000, result}, {16'h0000, e.res});
                check({e.name, "_result_hi"}, {16'h0000, result_hi}, {16'h0000, e.hi});
                check({e.name, "_ZCNV"}, {28'h0, Z, C, N, V}, {28'h0, e.flags});
            end
        end
    end

    task automatic single(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          input string name, input logic [15:0] r, input logic [3:0] f);
        @(negedge clk);
        Alu_Op = op; A = a; B = b; start = 1'b1;
        sb.push_back('{name: name, res: r, hi: 16'h0000, flags: f});
        @(negedge clk);
        start = 1'b0;
        check({name, "_done"}, {31'h0, done}, 32'h1);
    endtask

    task automatic multi(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input string name, input logic [15:0] r, input logic [15:0] h,
                         input logic [3:0] f, input int exp_lat, input bit inject);
        int n;
        int busy_cnt;
        @(negedge clk);
        Alu_Op = op; A = a; B = b; start = 1'b1;
        sb.push_back('{name: name, res: r, hi: h, flags: f});
        @(negedge clk);
        start = 1'b0;
        n = 1;
        busy_cnt = busy ? 1 : 0;
        while (!done && n < 100) begin
            if (inject && n == 5) begin
                start = 1'b1; Alu_Op = 4'd0; A = 16'h0001; B = 16'h0001;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
            if (busy) busy_cnt++;
        end
        start = 1'b0;
        check({name, "_latency"}, n - 1, exp_lat);
        check({name, "_busy_cycles"}, busy_cnt, exp_lat);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; Alu_Op = 4'd0; A = 16'h0; B = 16'h0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {result, result_hi}, 32'h0);
        check("reset_flags", {26'h0, Z, C, N, V, busy, done}, 32'h0);
        reset = 1'b0;

        single(4'd0, 16'hFFFF, 16'h0001, "add_wrap",   16'h0000, 4'b1100);
        single(4'd1, 16'h8000, 16'h0001, "sub_ovf",    16'h7FFF, 4'b0101);
        single(4'd5, 16'h8001, 16'h0001, "shl_carry",  16'h0002, 4'b0100);
        single(4'd6, 16'h0001, 16'h0000, "shr_zero",   16'h0001, 4'b0000);
        single(4'd6, 16'h8003, 16'h0011, "shr_mask",   16'h4001, 4'b0100);
        single(4'd2, 16'hF0F0, 16'h0FF0, "and",        16'h00F0, 4'b0000);
        single(4'd3, 16'h8000, 16'h0001, "or",         16'h8001, 4'b0010);
        single(4'd4, 16'hAAAA, 16'hAAAA, "xor_zero",   16'h0000, 4'b1000);
        single(4'd1, 16'h0005, 16'h0005, "sub_equal",  16'h0000, 4'b1100);
        single(4'd1, 16'h0001, 16'h0002, "sub_borrow", 16'hFFFF, 4'b0010);
        single(4'd0, 16'h7FFF, 16'h0001, "add_ovf",    16'h8000, 4'b0011);
        single(4'd15, 16'h1234, 16'h5678, "nop",       16'h0000, 4'b1000);

        multi(4'd7, 16'hFFFF, 16'hFFFF, "mul_max",   16'h0001, 16'hFFFE, 4'b0001, 16, 1'b1);
        multi(4'd7, 16'h0003, 16'h0005, "mul_small", 16'h000F, 16'h0000, 4'b0000, 16, 1'b0);
        multi(4'd8, 16'h0064, 16'h0007, "div_100_7", 16'h000E, 16'h0002, 4'b0000, 16, 1'b0);
        multi(4'd8, 16'h1234, 16'h0000, "div_zero",  16'hFFFF, 16'h1234, 4'b0011, 0, 1'b0);
        multi(4'd8, 16'hFFFF, 16'h0001, "div_by_1",  16'hFFFF, 16'h0000, 4'b0010, 16, 1'b0);

        // Abort a multiply with reset part-way through.
        @(negedge clk);
        Alu_Op = 4'd7; A = 16'hFFFF; B = 16'hFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        done_seen = 0;
        reset = 1'b1;
        @(negedge clk);
        check("abort_outputs", {result, result_hi}, 32'h0);
        check("abort_flags", {26'h0, Z, C, N, V, busy, done}, 32'h0);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_no_done", done_seen, 0);
        single(4'd0, 16'h0002, 16'h0003, "add_after_abort", 16'h0005, 4'b0000);

        repeat (3) @(negedge clk);
        check("sb_drain", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
